// File: rtl/imem_ctrl_if.sv
// Fetch and program-load bus between the core/boot loader and imem_ctrl.
interface imem_ctrl_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_fault;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic [3:0]  load_be;
  logic        load_fault;
  logic        init_busy;

  modport master (
    output fetch_req, fetch_addr, load_en, load_addr, load_data, load_be,
    input  fetch_ready, fetch_valid, fetch_instr, fetch_fault, load_fault, init_busy
  );

  modport slave (
    input  fetch_req, fetch_addr, load_en, load_addr, load_data, load_be,
    output fetch_ready, fetch_valid, fetch_instr, fetch_fault, load_fault, init_busy
  );
endinterface

// File: rtl/imem_ctrl.sv
// Instruction memory: NOP fill after reset, two-stage registered fetch path,
// byte-masked program loads, fault flags for misaligned/out-of-range accesses.
module imem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input logic        clk,
  input logic        rst_n,
  imem_ctrl_if.slave bus
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [AW-1:0] LAST = AW'(DEPTH_WORDS - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state, state_d;
  logic [AW-1:0] cnt, cnt_d;
  logic          fill_we;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] fidx, lidx;
  logic          fetch_acc, fetch_bad, load_bad, load_we;

  logic          busy_q, ready_q;
  logic          p_valid, p_fault;
  logic [31:0]   p_data;
  logic          valid_q, fault_q, lfault_q;
  logic [31:0]   instr_q;

  assign fidx      = bus.fetch_addr[AW+1:2];
  assign lidx      = bus.load_addr[AW+1:2];
  assign fetch_acc = bus.fetch_req && ready_q;
  // Full 32-bit range compare so high address bits never alias onto the array.
  assign fetch_bad = (bus.fetch_addr[1:0] != 2'b00) || (bus.fetch_addr >= BYTES);
  assign load_bad  = (bus.load_addr[1:0] != 2'b00) || (bus.load_addr >= BYTES) ||
                     (state != RUN);
  assign load_we   = bus.load_en && !load_bad;

  // Fill sequencer: one NOP word per cycle, then RUN until the next reset.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    fill_we = 1'b0;
    case (state)
      INIT: begin
        fill_we = 1'b1;
        if (cnt == LAST) state_d = RUN;
        else             cnt_d   = cnt + AW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      cnt      <= '0;
      busy_q   <= 1'b1;
      ready_q  <= 1'b0;
      p_valid  <= 1'b0;
      p_fault  <= 1'b0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      instr_q  <= NOP_WORD;
      lfault_q <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      busy_q   <= (state_d == INIT);
      ready_q  <= (state_d == RUN);
      p_valid  <= fetch_acc;
      p_fault  <= fetch_bad;
      valid_q  <= p_valid;
      fault_q  <= p_valid && p_fault;
      if (p_valid) instr_q <= p_fault ? NOP_WORD : p_data;
      lfault_q <= bus.load_en && load_bad;
    end
  end

  // Array read happens at the same edge as any write, giving read-before-write.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[cnt] <= NOP_WORD;
    end else if (load_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.load_be[b]) mem[lidx][8*b +: 8] <= bus.load_data[8*b +: 8];
      end
    end
    p_data <= mem[fidx];
  end

  assign bus.fetch_ready = ready_q;
  assign bus.init_busy   = busy_q;
  assign bus.fetch_valid = valid_q;
  assign bus.fetch_fault = fault_q;
  assign bus.fetch_instr = instr_q;
  assign bus.load_fault  = lfault_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl: cycle-level reference model plus
// directed fetch/load/fault/collision/streaming/reset scenarios.
module tb_imem_ctrl;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk;
  logic rst_n;
  imem_ctrl_if bus();

  imem_ctrl #(.DEPTH_WORDS(DEPTH), .NOP_WORD(NOP)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] instr;
    logic        fault;
  } rsp_t;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
    int          cyc;
  } got_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc_n = 0;

  // Reference model state
  logic [31:0] mm [DEPTH];
  int          edge_n;
  rsp_t        q[$];
  logic        exp_valid, exp_fault, exp_lf, exp_busy;
  logic [31:0] exp_instr;
  got_t        got[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %08h, expected %08h", nm, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    edge_n    = 0;
    q.delete();
    exp_valid = 1'b0;
    exp_fault = 1'b0;
    exp_instr = NOP;
    exp_lf    = 1'b0;
    exp_busy  = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) mm[i] = NOP;
  endfunction

  // One rising edge of the spec: responses due now emerge, new accepts queue up.
  function automatic void model_step();
    logic        rdy, bad;
    rsp_t        r;
    logic [31:0] fa, la;
    int          idx;
    edge_n++;
    rdy       = (edge_n > int'(DEPTH));
    exp_valid = 1'b0;
    exp_fault = 1'b0;
    if (q.size() > 0 && q[0].due == edge_n) begin
      r = q.pop_front();
      exp_valid = 1'b1;
      exp_instr = r.instr;
      exp_fault = r.fault;
    end
    fa = bus.fetch_addr;
    if (bus.fetch_req && rdy) begin
      r.due   = edge_n + 1;
      r.fault = (fa % 4 != 0) || (fa >= 32'(4 * DEPTH));
      r.instr = r.fault ? NOP : mm[int'(fa / 4)];
      q.push_back(r);
    end
    la     = bus.load_addr;
    exp_lf = 1'b0;
    if (bus.load_en) begin
      bad    = (la % 4 != 0) || (la >= 32'(4 * DEPTH)) || !rdy;
      exp_lf = bad;
      if (!bad) begin
        idx = int'(la / 4);
        for (int b = 0; b < 4; b++)
          if (bus.load_be[b]) mm[idx][8*b +: 8] = bus.load_data[8*b +: 8];
      end
    end
    exp_busy = (edge_n < int'(DEPTH));
  endfunction

  // Per-cycle compare at the falling edge, model advance at the rising edge.
  task automatic cyc();
    got_t g;
    @(negedge clk);
    chk("cyc_valid", 32'(bus.fetch_valid), 32'(exp_valid));
    chk("cyc_instr", bus.fetch_instr, exp_instr);
    if (exp_valid) chk("cyc_fault", 32'(bus.fetch_fault), 32'(exp_fault));
    chk("cyc_load_fault", 32'(bus.load_fault), 32'(exp_lf));
    chk("cyc_busy", 32'(bus.init_busy), 32'(exp_busy));
    chk("cyc_ready", 32'(bus.fetch_ready), 32'(!exp_busy));
    if (bus.fetch_valid) begin
      g.instr = bus.fetch_instr;
      g.fault = bus.fetch_fault;
      g.cyc   = cyc_n;
      got.push_back(g);
    end
    cyc_n++;
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic wait_init(input int n0, input string nm);
    int n = n0;
    while (bus.init_busy && n < 600) begin
      cyc();
      n++;
    end
    chk(nm, 32'(n), 32'(DEPTH));
  endtask

  task automatic fetch_ld(input logic [31:0] a, input logic do_ld, input logic [31:0] ld,
                          input logic [31:0] ei, input logic ef, input string nm);
    int lat = -1;
    got.delete();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    bus.load_en    = do_ld;
    bus.load_addr  = a;
    bus.load_data  = ld;
    bus.load_be    = 4'hF;
    cyc();
    bus.fetch_req = 1'b0;
    bus.load_en   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (got.size() > 0) begin
        lat = k;
        break;
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'd1);
    if (got.size() > 0) begin
      chk({nm, "_instr"}, got[0].instr, ei);
      chk({nm, "_fault"}, 32'(got[0].fault), 32'(ef));
    end
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ef,
                       input string nm);
    fetch_ld(a, 1'b0, 32'h0, ei, ef, nm);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic elf, input string nm);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    bus.load_be   = be;
    cyc();
    bus.load_en = 1'b0;
    chk(nm, 32'(bus.load_fault), 32'(elf));
  endtask

  task automatic stream();
    logic [31:0] ew [4];
    ew[0] = 32'h00BB00DD;
    ew[1] = 32'h00400113;
    ew[2] = 32'h00000063;
    ew[3] = 32'h00308213;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'(4 * i);
      end else begin
        bus.fetch_req = 1'b0;
      end
      cyc();
    end
    chk("stream_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk($sformatf("stream_word%0d", i), got[i].instr, ew[i]);
      chk($sformatf("stream_gap%0d", i), 32'(got[i].cyc - got[0].cyc), 32'(i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b1;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.load_en    = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;
    bus.load_be    = '0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", 32'(bus.init_busy), 32'd1);
    chk("rst_ready", 32'(bus.fetch_ready), 32'd0);
    chk("rst_valid", 32'(bus.fetch_valid), 32'd0);
    chk("rst_instr", bus.fetch_instr, NOP);
    chk("rst_load_fault", 32'(bus.load_fault), 32'd0);
    cyc();
    cyc();

    // Release; first cycle carries a fetch (dropped) and a load (rejected).
    rst_n = 1'b1;
    got.delete();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h0;
    bus.load_en    = 1'b1;
    bus.load_addr  = 32'h10;
    bus.load_data  = 32'hDEADBEEF;
    bus.load_be    = 4'hF;
    cyc();
    bus.fetch_req = 1'b0;
    bus.load_en   = 1'b0;
    chk("load_during_init", 32'(bus.load_fault), 32'd1);
    wait_init(1, "init_cycles");
    chk("init_fetch_dropped", 32'(got.size()), 32'd0);

    fetch(32'h3FC, NOP, 1'b0, "fetch_top");
    fetch(32'h10, NOP, 1'b0, "fetch_init_load_ignored");

    load(32'h0, 32'h00100093, 4'hF, 1'b0, "load_full");
    fetch(32'h0, 32'h00100093, 1'b0, "fetch_full");
    load(32'h0, 32'hAABBCCDD, 4'b0101, 1'b0, "load_masked");
    fetch(32'h0, 32'h00BB00DD, 1'b0, "fetch_masked");

    fetch(32'h2, NOP, 1'b1, "fetch_misaligned");
    fetch(32'h400, NOP, 1'b1, "fetch_oor");
    fetch(32'hFFFFFFFC, NOP, 1'b1, "fetch_no_wrap");
    fetch(32'h1000, NOP, 1'b1, "fetch_no_alias");

    load(32'h401, 32'h11111111, 4'hF, 1'b1, "load_0x401");
    load(32'h400, 32'h11111111, 4'hF, 1'b1, "load_0x400");
    load(32'h2, 32'h11111111, 4'hF, 1'b1, "load_misaligned");
    load(32'h0, 32'h22222222, 4'h0, 1'b0, "load_be_zero");
    fetch(32'h0, 32'h00BB00DD, 1'b0, "fetch_unchanged");

    load(32'h8, 32'h002081B3, 4'hF, 1'b0, "load_word8");
    fetch_ld(32'h8, 1'b1, 32'h00000063, 32'h002081B3, 1'b0, "collide_old");
    fetch(32'h8, 32'h00000063, 1'b0, "collide_new");

    load(32'h4, 32'h00400113, 4'hF, 1'b0, "load_word4");
    load(32'hC, 32'h00308213, 4'hF, 1'b0, "load_word12");
    stream();

    // Reset in the cycle after an accepted fetch.
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h0;
    cyc();
    bus.fetch_req = 1'b0;
    rst_n = 1'b0;
    model_reset();
    got.delete();
    #1;
    chk("midrst_valid", 32'(bus.fetch_valid), 32'd0);
    chk("midrst_instr", bus.fetch_instr, NOP);
    chk("midrst_busy", 32'(bus.init_busy), 32'd1);
    cyc();
    cyc();
    cyc();
    chk("midrst_no_response", 32'(got.size()), 32'd0);
    rst_n = 1'b1;

    // Reset again part-way through the fill; the sweep must restart.
    for (int i = 0; i < 50; i++) cyc();
    rst_n = 1'b0;
    model_reset();
    cyc();
    cyc();
    rst_n = 1'b1;
    wait_init(0, "reinit_cycles");

    fetch(32'h0, NOP, 1'b0, "refill_word0");
    fetch(32'h8, NOP, 1'b0, "refill_word8");
    fetch(32'hC, NOP, 1'b0, "refill_word12");
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
